// File: rtl/reg_cut_pkg.sv
// Shared types and helpers for the register-interface cut stage with timeout.
package reg_cut_pkg;

    localparam int unsigned RegAw = 32;
    localparam int unsigned RegDw = 32;

    // Read data returned when a peripheral never answers
    localparam logic [31:0] ErrDataDefault = 32'hBADCAB1E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } cut_state_e;

    typedef struct packed {
        logic [RegAw-1:0]   addr;
        logic               write;
        logic [RegDw-1:0]   wdata;
        logic [RegDw/8-1:0] wstrb;
        logic               valid;
    } reg_req_t;

    typedef struct packed {
        logic [RegDw-1:0] rdata;
        logic             error;
        logic             ready;
    } reg_rsp_t;

    // Bits needed to count 0..cycles; at least one bit so a disabled timeout still elaborates
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_cut_timeout.sv
// Register-interface cut: registers request and response paths and forces an
// error response when a peripheral leaves a request unanswered too long.
module reg_cut_timeout
    import reg_cut_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter int unsigned TimeoutCycles = 256,
    parameter logic [31:0] ErrData       = ErrDataDefault,
    parameter type         req_t         = reg_req_t,
    parameter type         rsp_t         = reg_rsp_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  req_t slv_req_i,
    output rsp_t slv_rsp_o,
    output req_t mst_req_o,
    input  rsp_t mst_rsp_i,
    output logic timeout_o,
    output logic busy_o
);

    localparam int unsigned SW        = DW / 8;
    localparam int unsigned CntW      = cnt_width(TimeoutCycles);
    localparam bit          TimeoutEn = (TimeoutCycles != 0);
    // Only compared when the timeout is enabled, so the wrap at zero is harmless
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    cut_state_e      state_q, state_d;
    req_t            req_q, req_d;
    rsp_t            rsp_q, rsp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            busy_q;

    // Next-state, request/response capture and ISSUE cycle counting
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_d       = rsp_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        req_d.valid = 1'b0;
        rsp_d.ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (slv_req_i.valid) begin
                    req_d.addr  = AW'(slv_req_i.addr);
                    req_d.write = slv_req_i.write;
                    req_d.wdata = DW'(slv_req_i.wdata);
                    req_d.wstrb = SW'(slv_req_i.wstrb);
                    req_d.valid = 1'b1;
                    cnt_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mst_rsp_i.ready) begin
                    // A real answer always beats a coincident timeout
                    rsp_d.rdata = DW'(mst_rsp_i.rdata);
                    rsp_d.error = mst_rsp_i.error;
                    rsp_d.ready = 1'b1;
                    state_d     = RESP;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    // Abandon the downstream request and answer upstream with an error
                    rsp_d.rdata = DW'(ErrData);
                    rsp_d.error = 1'b1;
                    rsp_d.ready = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    req_d.valid = 1'b1;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            rsp_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rsp_q     <= rsp_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign slv_rsp_o = rsp_q;
    assign mst_req_o = req_q;
    assign timeout_o = timeout_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_reg_cut_timeout.sv
// Bench for reg_cut_timeout: a transaction-level schedule precomputes stimulus
// and expected outputs for every cycle; one process compares on the falling edge.
module tb_reg_cut_timeout;
    import reg_cut_pkg::*;

    localparam int          Tmo = 8;
    localparam int          NC  = 2000;
    localparam logic [31:0] ERR = 32'hBADCAB1E;

    logic     clk;
    logic     rst;
    reg_req_t slv_req, mst_req;
    reg_rsp_t slv_rsp, mst_rsp;
    logic     timeout, busy;

    reg_cut_timeout #(.TimeoutCycles(Tmo)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .slv_req_i (slv_req),
        .slv_rsp_o (slv_rsp),
        .mst_req_o (mst_req),
        .mst_rsp_i (mst_rsp),
        .timeout_o (timeout),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle stimulus and expectations
    logic     s_rst [NC];
    reg_req_t s_req [NC];
    reg_rsp_t s_mrsp[NC];
    reg_req_t e_mreq[NC];
    reg_rsp_t e_srsp[NC];
    logic     e_tmo [NC];
    logic     e_busy[NC];
    logic     e_zero[NC];

    int cursor;
    int cyc;
    bit running;
    int n_chk;
    int n_pass;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    endtask

    // Append one transaction: gap g idle cycles, peripheral answers after d ISSUE
    // cycles (d >= Tmo means never), optional reset on ISSUE cycle abort_k
    task automatic add_txn(input int g, input int d, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input logic [31:0] pd, input logic pe, input int abort_k);
        int c0, n, last, ak;
        bit timed;
        reg_req_t r;
        cursor += g;
        c0    = cursor;
        timed = (d >= Tmo);
        n     = timed ? Tmo : d + 1;
        ak    = (abort_k >= n) ? n - 1 : abort_k;
        last  = (ak >= 0) ? c0 + 1 + ak : c0 + n + 1;
        r.addr = a; r.write = w; r.wdata = wd; r.wstrb = ws; r.valid = 1'b1;
        for (int c = c0; c <= last; c++) s_req[c] = r;
        for (int j = 0; j < n; j++) begin
            int c;
            if (ak >= 0 && j > ak) break;
            c = c0 + 1 + j;
            e_mreq[c] = r;
            e_busy[c] = 1'b1;
            s_mrsp[c].ready = (j == d);
            if (j == d) begin
                s_mrsp[c].rdata = pd;
                s_mrsp[c].error = pe;
            end
        end
        if (ak >= 0) begin
            s_rst[last]      = 1'b1;
            e_zero[last + 1] = 1'b1;
            cursor = last + 1;
            return;
        end
        e_srsp[c0 + n + 1].ready = 1'b1;
        e_srsp[c0 + n + 1].rdata = timed ? ERR : pd;
        e_srsp[c0 + n + 1].error = timed ? 1'b1 : pe;
        e_tmo[c0 + n + 1]  = timed;
        e_busy[c0 + n + 1] = 1'b1;
        cursor = c0 + n + 2;
    endtask

    task automatic apply(input int c);
        rst     = s_rst[c];
        slv_req = s_req[c];
        mst_rsp = s_mrsp[c];
    endtask

    // Compare DUT outputs against the schedule and a few hand-computed points
    always @(negedge clk) begin
        if (running && cyc >= 1) begin
            if (e_zero[cyc]) begin
                chk("rst_slv_rsp", 32'(slv_rsp != '0), 0);
                chk("rst_mst_req", 32'(mst_req != '0), 0);
                chk("rst_timeout", 32'(timeout), 0);
                chk("rst_busy",    32'(busy), 0);
            end else begin
                chk("mst_valid", 32'(mst_req.valid), 32'(e_mreq[cyc].valid));
                chk("busy",      32'(busy),          32'(e_busy[cyc]));
                chk("slv_ready", 32'(slv_rsp.ready), 32'(e_srsp[cyc].ready));
                chk("timeout",   32'(timeout),       32'(e_tmo[cyc]));
                if (e_mreq[cyc].valid) begin
                    chk("mst_addr",  mst_req.addr,         e_mreq[cyc].addr);
                    chk("mst_write", 32'(mst_req.write),   32'(e_mreq[cyc].write));
                    chk("mst_wdata", mst_req.wdata,        e_mreq[cyc].wdata);
                    chk("mst_wstrb", 32'(mst_req.wstrb),   32'(e_mreq[cyc].wstrb));
                end
                if (e_srsp[cyc].ready) begin
                    chk("slv_rdata", slv_rsp.rdata,        e_srsp[cyc].rdata);
                    chk("slv_error", 32'(slv_rsp.error),   32'(e_srsp[cyc].error));
                end
            end
            case (cyc)
                2:  begin chk("lit_rd_mvalid", 32'(mst_req.valid), 1);
                          chk("lit_rd_addr", mst_req.addr, 32'h0000_0010);
                          chk("lit_rd_write", 32'(mst_req.write), 0); end
                3:  begin chk("lit_rd_ready", 32'(slv_rsp.ready), 1);
                          chk("lit_rd_rdata", slv_rsp.rdata, 32'h1234_5678); end
                10: begin chk("lit_wr_wdata", mst_req.wdata, 32'hA5A5_A5A5);
                          chk("lit_wr_addr", mst_req.addr, 32'h0000_0040); end
                11: chk("lit_wr_error", 32'({slv_rsp.ready, slv_rsp.error}), 3);
                20: chk("lit_to_mvalid_last", 32'(mst_req.valid), 1);
                21: begin chk("lit_to_pulse", 32'(timeout), 1);
                          chk("lit_to_rdata", slv_rsp.rdata, 32'hBADC_AB1E);
                          chk("lit_to_mvalid_off", 32'(mst_req.valid), 0); end
                22: chk("lit_to_pulse_end", 32'(timeout), 0);
                31: begin chk("lit_race_rdata", slv_rsp.rdata, 32'h0000_0001);
                          chk("lit_race_notmo", 32'({timeout, slv_rsp.error}), 0); end
                34: chk("lit_b2b_ready0", 32'(slv_rsp.ready), 1);
                35: chk("lit_b2b_busy_low", 32'(busy), 0);
                37: chk("lit_b2b_ready1", 32'(slv_rsp.ready), 1);
                44: begin chk("lit_post_rst_ready", 32'(slv_rsp.ready), 1);
                          chk("lit_post_rst_rdata", slv_rsp.rdata, 32'hCAFE_0044); end
                default: ;
            endcase
        end
    end

    initial begin
        int nrun;
        n_chk = 0; n_pass = 0; cyc = 0; running = 1'b0;
        // Idle defaults with random noise on ignored fields
        for (int c = 0; c < NC; c++) begin
            s_rst[c] = 1'b0;
            s_req[c].addr  = $urandom; s_req[c].write = 1'($urandom);
            s_req[c].wdata = $urandom; s_req[c].wstrb = 4'($urandom);
            s_req[c].valid = 1'b0;
            s_mrsp[c].rdata = $urandom; s_mrsp[c].error = 1'($urandom);
            s_mrsp[c].ready = 1'($urandom);
            e_mreq[c] = '0; e_srsp[c] = '0;
            e_tmo[c] = 1'b0; e_busy[c] = 1'b0; e_zero[c] = 1'b0;
        end
        s_rst[0] = 1'b1;
        e_zero[1] = 1'b1;
        cursor = 1;
        // Directed transactions
        add_txn(0, 0,  32'h10, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 1'b0, -1);
        add_txn(0, 5,  32'h40, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b1, -1);
        add_txn(0, 99, 32'h80, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, -1);
        add_txn(0, 7,  32'h84, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, -1);
        add_txn(0, 0,  32'h90, 1'b0, 32'h0, 4'h0, 32'h1111_0001, 1'b0, -1);
        add_txn(0, 0,  32'h94, 1'b0, 32'h0, 4'h0, 32'h2222_0002, 1'b1, -1);
        add_txn(0, 99, 32'hA0, 1'b1, 32'h5, 4'h3, 32'h0, 1'b0, 2);
        add_txn(0, 0,  32'hA4, 1'b0, 32'h0, 4'h0, 32'hCAFE_0044, 1'b0, -1);
        // Randomized transactions
        while (cursor < NC - 30) begin
            int g, d, sel, ab;
            g   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            sel = $urandom_range(0, 9);
            d   = (sel < 6) ? $urandom_range(0, 6) : (sel < 8) ? Tmo - 1 :
                  (sel < 9) ? Tmo + 5 : $urandom_range(0, Tmo);
            ab  = ($urandom_range(0, 11) == 0) ? $urandom_range(0, Tmo - 1) : -1;
            add_txn(g, d, $urandom, 1'($urandom), $urandom, 4'($urandom),
                    $urandom, 1'($urandom), ab);
        end
        nrun = cursor + 3;

        running = 1'b1;
        apply(0);
        for (int c = 1; c < nrun; c++) begin
            @(posedge clk);
            #2;
            cyc = c;
            apply(c);
        end
        @(posedge clk);
        #2;
        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
